// File: rtl/midori_seq_pkg.sv
// Shared types and default dimensions for the Midori masked S-box sequencer.
// Holds the FSM state enum, the state/nibble/randomness widths and the
// nibble index type used by the issue and collect counters.
package midori_seq_pkg;

  localparam int unsigned NIBBLES  = 16;
  localparam int unsigned SBOX_LAT = 4;
  localparam int unsigned R_OFS    = 2;
  localparam int unsigned RW       = 8;

  localparam int unsigned STATE_W  = 4 * NIBBLES;
  localparam int unsigned IDX_W    = $clog2(NIBBLES);
  localparam int unsigned POS_W    = IDX_W + 2;

  typedef logic [IDX_W-1:0] nib_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/midori_share_shifter.sv
// Three-share loadable nibble shift register feeding the S-box one nibble
// at a time. Each shift rotates the shares right by one nibble so the next
// nibble to issue always sits in bits [3:0].
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            capture d1..d3 (takes priority over shift)
//   shift           rotate all shares right by one nibble
//   clear           zero all shares (highest priority after reset)
//   d1, d2, d3      share load data
//   nib1..nib3      current low nibble of each share
module midori_share_shifter
  import midori_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic               clear,
  input  logic [STATE_W-1:0] d1,
  input  logic [STATE_W-1:0] d2,
  input  logic [STATE_W-1:0] d3,
  output logic [3:0]         nib1,
  output logic [3:0]         nib2,
  output logic [3:0]         nib3
);

  logic [STATE_W-1:0] sr1, sr2, sr3;

  // Share storage: clear wipes residue, load captures, shift rotates.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr1 <= '0;
      sr2 <= '0;
      sr3 <= '0;
    end else if (load) begin
      sr1 <= d1;
      sr2 <= d2;
      sr3 <= d3;
    end else if (shift) begin
      sr1 <= {sr1[3:0], sr1[STATE_W-1:4]};
      sr2 <= {sr2[3:0], sr2[STATE_W-1:4]};
      sr3 <= {sr3[3:0], sr3[STATE_W-1:4]};
    end
  end

  assign nib1 = sr1[3:0];
  assign nib2 = sr2[3:0];
  assign nib3 = sr3[3:0];

endmodule

// File: rtl/midori_sbox_seq.sv
// Sequencer streaming a 64-bit 3-share Midori state through one shared
// 4-bit 3-share masked S-box, one nibble per cycle. Consumes one fresh
// random word per issued nibble, delays it to the S-box refresh stage,
// tracks in-flight nibbles with valid tags and reassembles the results.
// Optional feature macro: SHARE_CLEAR_EN (zero result regs on handshake and
// input shift regs after the last issue).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start / start_ready        state request handshake (ready in IDLE)
//   st1_in..st3_in             input shares, sampled on accepted start
//   rnd / rnd_valid / rnd_ready  PRNG stream, consumed on each issue
//   sb_in1..sb_in3, sb_r       to the external S-box (nibble shares, refresh)
//   sb_out1..sb_out3           from the external S-box
//   out_valid / out_ready      result handshake (valid in DONE)
//   st1_out..st3_out           result shares
module midori_sbox_seq
  import midori_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               start_ready,
  input  logic [STATE_W-1:0] st1_in,
  input  logic [STATE_W-1:0] st2_in,
  input  logic [STATE_W-1:0] st3_in,
  input  logic [RW-1:0]      rnd,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  output logic [3:0]         sb_in1,
  output logic [3:0]         sb_in2,
  output logic [3:0]         sb_in3,
  output logic [RW-1:0]      sb_r,
  input  logic [3:0]         sb_out1,
  input  logic [3:0]         sb_out2,
  input  logic [3:0]         sb_out3,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] st1_out,
  output logic [STATE_W-1:0] st2_out,
  output logic [STATE_W-1:0] st3_out
);

  seq_state_t          state;
  nib_idx_t            issue_cnt;
  nib_idx_t            collect_cnt;
  logic [SBOX_LAT-1:0] tag_sr;
  logic [RW-1:0]       r_dly [R_OFS];
  logic [3:0]          nib1, nib2, nib3;
  logic [POS_W-1:0]    wr_pos;
  logic                accept, issue, last_issue, capture, last_capture;
  logic                shift_clear;

  // Handshake flags decode straight from the state register.
  assign start_ready = (state == ST_IDLE);
  assign rnd_ready   = (state == ST_RUN);
  assign out_valid   = (state == ST_DONE);

  // Per-cycle issue/capture decisions.
  always_comb begin
    accept       = (state == ST_IDLE) && start;
    issue        = (state == ST_RUN) && rnd_valid;
    last_issue   = issue && (issue_cnt == nib_idx_t'(NIBBLES - 1));
    capture      = ((state == ST_RUN) || (state == ST_DRAIN)) && tag_sr[SBOX_LAT-1];
    last_capture = capture && (collect_cnt == nib_idx_t'(NIBBLES - 1));
    wr_pos       = {collect_cnt, 2'b00};
  end

  // Bubbles and non-RUN cycles present an all-zero nibble to the S-box.
  assign sb_in1 = issue ? nib1 : 4'h0;
  assign sb_in2 = issue ? nib2 : 4'h0;
  assign sb_in3 = issue ? nib3 : 4'h0;
  assign sb_r   = r_dly[R_OFS-1];

`ifdef SHARE_CLEAR_EN
  assign shift_clear = last_issue;
`else
  assign shift_clear = 1'b0;
`endif

  midori_share_shifter u_in_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (issue),
    .clear (shift_clear),
    .d1    (st1_in),
    .d2    (st2_in),
    .d3    (st3_in),
    .nib1  (nib1),
    .nib2  (nib2),
    .nib3  (nib3)
  );

  // FSM, in-flight tags, refresh delay line and result reassembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      issue_cnt   <= '0;
      collect_cnt <= '0;
      tag_sr      <= '0;
      for (int i = 0; i < R_OFS; i++) r_dly[i] <= '0;
      st1_out     <= '0;
      st2_out     <= '0;
      st3_out     <= '0;
    end else begin
      tag_sr   <= {tag_sr[SBOX_LAT-2:0], issue};
      r_dly[0] <= issue ? rnd : '0;
      for (int i = 1; i < R_OFS; i++) r_dly[i] <= r_dly[i-1];

      if (issue) issue_cnt <= nib_idx_t'(issue_cnt + 1'b1);

      if (capture) begin
        st1_out[wr_pos +: 4] <= sb_out1;
        st2_out[wr_pos +: 4] <= sb_out2;
        st3_out[wr_pos +: 4] <= sb_out3;
        collect_cnt          <= nib_idx_t'(collect_cnt + 1'b1);
      end

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_RUN;
            issue_cnt   <= '0;
            collect_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (last_issue) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (last_capture) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
`ifdef SHARE_CLEAR_EN
            st1_out <= '0;
            st2_out <= '0;
            st3_out <= '0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_midori_sbox_seq.sv
// Self-checking bench for midori_sbox_seq with a behavioural 4-cycle masked
// S-box wired to the sb_* ports. Result checks use the XOR of the shares.
`timescale 1ns/1ps
module tb_midori_sbox_seq;
  import midori_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, start_ready;
  logic [63:0] st1_in, st2_in, st3_in;
  logic [7:0]  rnd;
  logic        rnd_valid, rnd_ready;
  logic [3:0]  sb_in1, sb_in2, sb_in3;
  logic [7:0]  sb_r;
  logic [3:0]  sb_out1, sb_out2, sb_out3;
  logic        out_valid, out_ready;
  logic [63:0] st1_out, st2_out, st3_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  midori_sbox_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_ready(start_ready),
    .st1_in     (st1_in),
    .st2_in     (st2_in),
    .st3_in     (st3_in),
    .rnd        (rnd),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .sb_in1     (sb_in1),
    .sb_in2     (sb_in2),
    .sb_in3     (sb_in3),
    .sb_r       (sb_r),
    .sb_out1    (sb_out1),
    .sb_out2    (sb_out2),
    .sb_out3    (sb_out3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .st1_out    (st1_out),
    .st2_out    (st2_out),
    .st3_out    (st3_out)
  );

  // Bench S-box permutation and a 4-stage masked pipeline; refresh uses sb_r
  // in the third cycle after issue, output valid in the fourth.
  logic [3:0]  sbox_tbl [16] = '{4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
                                 4'h8, 4'h9, 4'h0, 4'h6, 4'h2, 4'h5, 4'h4, 4'h1};
  logic [11:0] m1 = '0, m2 = '0, m3 = '0, m4 = '0;

  always @(posedge clk) begin
    m1 <= {sbox_tbl[sb_in1 ^ sb_in2 ^ sb_in3], 8'h00};
    m2 <= m1;
    m3 <= {m2[11:8] ^ sb_r[3:0] ^ sb_r[7:4], sb_r[3:0], sb_r[7:4]};
    m4 <= m3;
  end

  assign sb_out1 = m4[11:8];
  assign sb_out2 = m4[7:4];
  assign sb_out3 = m4[3:0];

  typedef struct {
    logic [63:0] a, b, c;
    logic [63:0] exp_xor;
    int          stall;    // 0: rnd always valid, 1: 1,0,1,0..., 2: 1,1,0,...
    int          exp_lat;
    int          hold;     // cycles out_ready stays low in DONE
    int          rst_at;   // nonzero: assert rst at this cycle of the run
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic pat_valid(input int mode, input int k);
    case (mode)
      1:       return (k % 2) == 1;
      2:       return (k % 3) != 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_op(input vec_t v, input int idx);
    logic [7:0]  exp_r [256];
    logic [63:0] a, h1, h2, h3;
    logic [7:0]  er;
    int          issues, lat;
    bit          done, fire;
    a = v.a;
    for (int i = 0; i < 256; i++) exp_r[i] = 8'h00;
    issues = 0;
    lat    = -1;
    done   = 1'b0;

    // Cycle 0: start accepted at its closing edge.
    @(negedge clk);
    check($sformatf("v%0d_start_ready_idle", idx), 64'(start_ready), 64'd1);
    st1_in = v.a; st2_in = v.b; st3_in = v.c;
    start = 1'b1; rnd_valid = 1'b0; out_ready = 1'b0;

    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      er = (k >= 3) ? exp_r[k-2] : 8'h00;
      check($sformatf("v%0d_sb_r_c%0d", idx, k), 64'(sb_r), 64'(er));
      if (out_valid) begin
        lat  = k;
        done = 1'b1;
        break;
      end
      if (v.rst_at == k) begin
        rst = 1'b1; rnd_valid = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_rst_start_ready", idx), 64'(start_ready), 64'd1);
        check($sformatf("v%0d_rst_out_valid", idx), 64'(out_valid), 64'd0);
        check($sformatf("v%0d_rst_rnd_ready", idx), 64'(rnd_ready), 64'd0);
        check($sformatf("v%0d_rst_sb_r", idx), 64'(sb_r), 64'd0);
        check($sformatf("v%0d_rst_outs", idx), st1_out | st2_out | st3_out, 64'd0);
        rst = 1'b0;
        return;
      end
      if (k % 5 == 2) begin
        check($sformatf("v%0d_busy_start_ready_c%0d", idx, k), 64'(start_ready), 64'd0);
        start = 1'b1;
        st1_in = 64'hDEAD_BEEF_0BAD_F00D; st2_in = 64'h1357_9BDF_2468_ACE0; st3_in = '1;
      end
      rnd_valid = pat_valid(v.stall, k);
      rnd       = 8'(issues + 1);
      fire      = rnd_ready && rnd_valid;
      #1;
      if (fire && issues < 16) begin
        check($sformatf("v%0d_sb_in_n%0d", idx, issues),
              64'({sb_in1, sb_in2, sb_in3}),
              64'({a[4*issues +: 4], v.b[4*issues +: 4], v.c[4*issues +: 4]}));
        exp_r[k] = rnd;
        issues++;
      end else begin
        check($sformatf("v%0d_sb_in_bubble_c%0d", idx, k),
              64'({sb_in1, sb_in2, sb_in3}), 64'd0);
      end
    end

    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL v%0d_timeout: out_valid not seen within 200 cycles", idx);
      return;
    end
    check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
    check($sformatf("v%0d_result", idx), st1_out ^ st2_out ^ st3_out, v.exp_xor);

    h1 = st1_out; h2 = st2_out; h3 = st3_out;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      start = (i == 3);
      check($sformatf("v%0d_hold_valid_%0d", idx, i), 64'(out_valid), 64'd1);
      check($sformatf("v%0d_hold_stable_%0d", idx, i),
            (st1_out ^ h1) | (st2_out ^ h2) | (st3_out ^ h3), 64'd0);
      if (i == 3)
        check($sformatf("v%0d_done_start_ready", idx), 64'(start_ready), 64'd0);
    end
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("v%0d_post_valid", idx), 64'(out_valid), 64'd0);
    check($sformatf("v%0d_post_start_ready", idx), 64'(start_ready), 64'd1);
`ifdef SHARE_CLEAR_EN
    check($sformatf("v%0d_post_cleared", idx), st1_out | st2_out | st3_out, 64'd0);
`else
    check($sformatf("v%0d_post_retained", idx),
          (st1_out ^ h1) | (st2_out ^ h2) | (st3_out ^ h3), 64'd0);
`endif
  endtask

  initial begin
    vec_t        tbl [6];
    logic [63:0] base, mb, mc;
    base = 64'h0123_4567_89AB_CDEF;
    mb   = 64'h5A5A_1234_DEAD_BEEF;
    mc   = 64'h0F0F_F0F0_1357_9BDF;
    tbl[0] = '{base, 64'd0, 64'd0, 64'hCAD3_EBF7_8906_2541, 0, 21, 10, 0};
    tbl[1] = '{base ^ mb ^ mc, mb, mc, 64'hCAD3_EBF7_8906_2541, 1, 36, 2, 0};
    tbl[2] = '{base, mb, mc ^ mb, 64'd0, 0, 0, 0, 8};
    tbl[3] = '{base, 64'd0, 64'd0, 64'hCAD3_EBF7_8906_2541, 0, 21, 0, 0};
    tbl[4] = '{64'd0, 64'd0, 64'd0, 64'hCCCC_CCCC_CCCC_CCCC, 0, 21, 1, 0};
    tbl[5] = '{64'hCCCC_CCCC_CCCC_CCCC, 64'h1111_1111_1111_1111,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111, 2, 28, 3, 0};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0; rnd_valid = 1'b0; rnd = 8'h00;
    st1_in = '0; st2_in = '0; st3_in = '0;
    repeat (2) @(negedge clk);
    check("reset_start_ready", 64'(start_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_rnd_ready", 64'(rnd_ready), 64'd0);
    check("reset_sb_r", 64'(sb_r), 64'd0);
    check("reset_sb_in", 64'({sb_in1, sb_in2, sb_in3}), 64'd0);
    check("reset_outs", st1_out | st2_out | st3_out, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_op(tbl[i], i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
